// File: rtl/chnlnk_frame_rcvr_fsm_pkg.sv
// chnlnk_frame_rcvr_fsm_pkg: framing constants and state encoding shared by both link ends
package chnlnk_frame_rcvr_fsm_pkg;
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_W4SMP  = 3'd2,
    ST_DATA   = 3'd3,
    ST_TAIL   = 3'd4,
    ST_W4LAST = 3'd5,
    ST_HUNT   = 3'd6
  } rcv_state_t;
  localparam int HDR_WORDS = 4;
  localparam int LAST_DATA = 95;
  localparam int LAST_TAIL = 98;
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;
endpackage

// File: rtl/chnlnk_crc16.sv
// chnlnk_crc16: one-word (16 bits, MSB first) CRC-16-CCITT update
module chnlnk_crc16
  import chnlnk_frame_rcvr_fsm_pkg::*;
(
  input  logic [15:0] crc,
  input  logic [15:0] din,
  output logic [15:0] crc_nxt
);
  logic [15:0] c;
  always_comb begin
    c = crc;
    for (int i = 15; i >= 0; i--)
      c = {c[14:0], 1'b0} ^ ((c[15] ^ din[i]) ? CRC_POLY : 16'h0000);
  end
  assign crc_nxt = c;
endmodule

// File: rtl/chnlnk_frame_rcvr_fsm.sv
// chnlnk_frame_rcvr_fsm: checks channel-link framing and per-sample CRC, forwards tagged data words
module chnlnk_frame_rcvr_fsm
  import chnlnk_frame_rcvr_fsm_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] DIN,
  input  logic        DV,
  input  logic        HDR_FLG,
  input  logic        LAST_FLG,
  input  logic [6:0]  SAMP_MAX,
  output logic [15:0] DOUT,
  output logic        DOUT_VLD,
  output logic [6:0]  SMP,
  output logic [6:0]  WRD,
  output logic        SMP_DONE,
  output logic        FRM_DONE,
  output logic        CRC_ERR,
  output logic        SEQ_ERR,
  output logic [2:0]  RCV_STATE
);
  rcv_state_t state, state_nxt;
  logic [6:0] wrd, wrd_nxt, smp, smp_nxt, smp_o_nxt, wrd_o_nxt;
  logic [15:0] crc, crc_nxt, crc_upd, dout_nxt;
  logic hdr, acc, hdr_end, data_nxt, tail_end;
  logic smp_done_nxt, frm_done_nxt, crc_err_nxt, seq_err_nxt;
  assign hdr = DV & HDR_FLG;
  assign acc = DV & ~HDR_FLG & ~LAST_FLG;
  assign hdr_end = state == ST_HDR && wrd == 7'(HDR_WORDS - 1);
  assign RCV_STATE = state;
  chnlnk_crc16 u_crc (
    .crc    (state == ST_W4SMP ? CRC_INIT : crc),
    .din    (DIN),
    .crc_nxt(crc_upd)
  );
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      wrd <= '0;
      smp <= '0;
      crc <= CRC_INIT;
      DOUT <= '0;
      DOUT_VLD <= 1'b0;
      SMP <= '0;
      WRD <= '0;
      SMP_DONE <= 1'b0;
      FRM_DONE <= 1'b0;
      CRC_ERR <= 1'b0;
      SEQ_ERR <= 1'b0;
    end else begin
      state <= state_nxt;
      wrd <= wrd_nxt;
      smp <= smp_nxt;
      crc <= crc_nxt;
      DOUT <= dout_nxt;
      DOUT_VLD <= data_nxt;
      SMP <= smp_o_nxt;
      WRD <= wrd_o_nxt;
      SMP_DONE <= smp_done_nxt;
      FRM_DONE <= frm_done_nxt;
      CRC_ERR <= crc_err_nxt;
      SEQ_ERR <= seq_err_nxt;
    end
  end
  // Priority: header word, then LAST_FLG, then ordinary valid word
  always_comb begin
    state_nxt = state;
    wrd_nxt = wrd;
    smp_nxt = smp;
    crc_nxt = crc;
    if (hdr) begin
      state_nxt = hdr_end ? ST_W4SMP : ST_HDR;
      wrd_nxt = state == ST_HDR ? wrd + 7'd1 : 7'd1;
      smp_nxt = hdr_end ? 7'd0 : smp;
    end else if (LAST_FLG) begin
      state_nxt = state == ST_HUNT ? ST_HUNT : ST_IDLE;
    end else if (DV) begin
      case (state)
        ST_HDR, ST_W4LAST: state_nxt = ST_HUNT;
        ST_W4SMP: begin
          crc_nxt = crc_upd;
          wrd_nxt = 7'd1;
          state_nxt = ST_DATA;
        end
        ST_DATA: begin
          crc_nxt = crc_upd;
          wrd_nxt = wrd + 7'd1;
          state_nxt = wrd == 7'(LAST_DATA) ? ST_TAIL : ST_DATA;
        end
        ST_TAIL: begin
          wrd_nxt = wrd == 7'(LAST_TAIL) ? wrd : wrd + 7'd1;
          state_nxt = wrd != 7'(LAST_TAIL) ? ST_TAIL : smp == SAMP_MAX ? ST_W4LAST : ST_W4SMP;
          smp_nxt = wrd == 7'(LAST_TAIL) && smp != SAMP_MAX ? smp + 7'd1 : smp;
        end
        default: ;
      endcase
    end
  end
  always_comb begin
    data_nxt = acc && (state == ST_W4SMP || state == ST_DATA);
    tail_end = acc && state == ST_TAIL && wrd == 7'(LAST_TAIL);
    dout_nxt = data_nxt ? DIN : DOUT;
    smp_o_nxt = data_nxt ? smp : SMP;
    wrd_o_nxt = data_nxt ? (state == ST_W4SMP ? 7'd0 : wrd) : WRD;
    smp_done_nxt = tail_end;
    crc_err_nxt = tail_end && DIN != crc;
    frm_done_nxt = LAST_FLG && state == ST_W4LAST;
    seq_err_nxt = hdr ? !(state inside {ST_IDLE, ST_HDR, ST_HUNT} || (state == ST_W4LAST && LAST_FLG))
                : LAST_FLG ? !(state inside {ST_IDLE, ST_W4LAST, ST_HUNT})
                : DV && (state inside {ST_HDR, ST_W4LAST});
  end
endmodule

// File: tb/tb_chnlnk_frame_rcvr_fsm.sv
// tb_chnlnk_frame_rcvr_fsm: randomized frames checked against a frame-level reference model
module tb_chnlnk_frame_rcvr_fsm;
  logic CLK = 1'b0, RST, DV, HDR_FLG, LAST_FLG;
  logic [15:0] DIN, DOUT;
  logic [6:0] SAMP_MAX, SMP, WRD;
  logic DOUT_VLD, SMP_DONE, FRM_DONE, CRC_ERR, SEQ_ERR;
  logic [2:0] RCV_STATE;

  chnlnk_frame_rcvr_fsm dut (
    .CLK(CLK), .RST(RST), .DIN(DIN), .DV(DV), .HDR_FLG(HDR_FLG), .LAST_FLG(LAST_FLG),
    .SAMP_MAX(SAMP_MAX), .DOUT(DOUT), .DOUT_VLD(DOUT_VLD), .SMP(SMP), .WRD(WRD),
    .SMP_DONE(SMP_DONE), .FRM_DONE(FRM_DONE), .CRC_ERR(CRC_ERR), .SEQ_ERR(SEQ_ERR),
    .RCV_STATE(RCV_STATE)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0, n_pass = 0;
  logic [29:0] exp_q[$], obs_q[$];
  int exp_sd, exp_ce, exp_ce_at, n_sd, n_ce, ce_at, n_fd, n_se;
  logic fd_now;

  function automatic logic [15:0] crc_msg(input logic [15:0] w[96]);
    logic [15:0] c = 16'hFFFF;
    for (int i = 0; i < 96 * 16; i++) begin
      logic b = w[i / 16][15 - (i % 16)];
      c = (c[15] ^ b) ? {c[14:0], 1'b0} ^ 16'h1021 : {c[14:0], 1'b0};
    end
    return c;
  endfunction

  function automatic int first_bad();
    int n = exp_q.size() < obs_q.size() ? exp_q.size() : obs_q.size();
    for (int i = 0; i < n; i++) if (obs_q[i] !== exp_q[i]) return i;
    return exp_q.size() == obs_q.size() ? -1 : n;
  endfunction

  task automatic clear_obs();
    exp_q.delete(); obs_q.delete();
    exp_sd = 0; exp_ce = 0; exp_ce_at = -1;
    n_sd = 0; n_ce = 0; ce_at = -1; n_fd = 0; n_se = 0; fd_now = 1'b0;
  endtask

  task automatic cyc(input logic dv, input logic hdr, input logic last, input logic [15:0] d);
    DV = dv; HDR_FLG = hdr; LAST_FLG = last; DIN = d;
    @(posedge CLK); #1;
    if (DOUT_VLD) obs_q.push_back({SMP, WRD, DOUT});
    if (SMP_DONE) n_sd++;
    if (CRC_ERR) begin n_ce++; ce_at = n_sd - 1; end
    if (FRM_DONE) n_fd++;
    if (SEQ_ERR) n_se++;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic gap(input bit en);
    if (en && $urandom_range(0, 9) < 3)
      repeat ($urandom_range(1, 3)) cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0, 16'($urandom));
  endtask

  // stop_at >= 0 ends the frame after that many data words of sample 0
  task automatic send_frame(input int sm, input bit gaps, input int bad_smp, input int nhdr, input int stop_at);
    logic [15:0] sw[96];
    logic [15:0] d;
    SAMP_MAX = 7'(sm);
    for (int h = 0; h < nhdr; h++) begin
      if (h > 0) gap(gaps);
      cyc(1'b1, 1'b1, 1'b0, 16'($urandom));
    end
    for (int s = 0; s <= sm; s++) begin
      for (int w = 0; w < 99; w++) begin
        if (s == 0 && w == stop_at) return;
        gap(gaps);
        d = 16'($urandom);
        if (w < 96) begin
          sw[w] = d;
          exp_q.push_back({7'(s), 7'(w), d});
        end else if (w == 98) begin
          d = crc_msg(sw) ^ (s == bad_smp ? 16'($urandom_range(1, 16'hFFFF)) : 16'h0);
          if (s == bad_smp) begin exp_ce++; exp_ce_at = exp_sd; end
          exp_sd++;
        end
        cyc(1'b1, 1'b0, 1'b0, d);
      end
    end
    gap(gaps);
    cyc(1'b0, 1'b0, 1'b1, 16'h0);
    fd_now = FRM_DONE;
  endtask

  task automatic test_reset();
    clear_obs();
    RST = 1'b1;
    repeat (3) cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
    n_chk++; if (DOUT !== 16'h0) $display("FAIL reset_dout got %h want 0000", DOUT); else n_pass++;
    n_chk++; if (DOUT_VLD !== 1'b0) $display("FAIL reset_vld got %b want 0", DOUT_VLD); else n_pass++;
    n_chk++; if (SMP !== 7'd0 || WRD !== 7'd0) $display("FAIL reset_idx got smp %0d wrd %0d want 0 0", SMP, WRD); else n_pass++;
    n_chk++; if ({SMP_DONE, FRM_DONE, CRC_ERR, SEQ_ERR} !== 4'b0) $display("FAIL reset_pulses got %b want 0000", {SMP_DONE, FRM_DONE, CRC_ERR, SEQ_ERR}); else n_pass++;
    n_chk++; if (RCV_STATE !== 3'd0) $display("FAIL reset_state got %0d want 0", RCV_STATE); else n_pass++;
    RST = 1'b0;
    idle(1);
  endtask

  task automatic test_clean();
    int b;
    clear_obs();
    send_frame(0, 1'b0, -1, 4, -1);
    idle(2);
    b = first_bad();
    n_chk++; if (obs_q.size() != 96) $display("FAIL clean_count got %0d want 96", obs_q.size()); else n_pass++;
    n_chk++; if (b != -1) $display("FAIL clean_data idx %0d got %h want %h", b, obs_q[b], exp_q[b]); else n_pass++;
    n_chk++; if (n_sd != 1 || n_ce != 0) $display("FAIL clean_smp got done %0d crcerr %0d want 1 0", n_sd, n_ce); else n_pass++;
    n_chk++; if (fd_now !== 1'b1 || n_fd != 1) $display("FAIL clean_frm got now %b n %0d want 1 1", fd_now, n_fd); else n_pass++;
    n_chk++; if (n_se != 0) $display("FAIL clean_seq got %0d want 0", n_se); else n_pass++;
  endtask

  task automatic test_gaps();
    int b;
    clear_obs();
    send_frame(2, 1'b1, -1, 4, -1);
    idle(2);
    b = first_bad();
    n_chk++; if (b != -1) $display("FAIL gaps_data idx %0d got %0d want %0d entries", b, obs_q.size(), exp_q.size()); else n_pass++;
    n_chk++; if (obs_q.size() != 288 || obs_q[287][29:23] !== 7'd2) $display("FAIL gaps_last_smp got n %0d want 288 ending in sample 2", obs_q.size()); else n_pass++;
    n_chk++; if (n_sd != 3 || n_ce != 0) $display("FAIL gaps_smp got done %0d crcerr %0d want 3 0", n_sd, n_ce); else n_pass++;
    n_chk++; if (fd_now !== 1'b1 || n_fd != 1 || n_se != 0) $display("FAIL gaps_frm got fd %b/%0d seq %0d want 1/1 0", fd_now, n_fd, n_se); else n_pass++;
  endtask

  task automatic test_crc_err();
    int b;
    clear_obs();
    send_frame(2, 1'b1, 1, 4, -1);
    idle(2);
    b = first_bad();
    n_chk++; if (b != -1) $display("FAIL crc_data idx %0d", b); else n_pass++;
    n_chk++; if (n_ce != exp_ce || ce_at != exp_ce_at) $display("FAIL crc_err got %0d at %0d want %0d at %0d", n_ce, ce_at, exp_ce, exp_ce_at); else n_pass++;
    n_chk++; if (n_sd != exp_sd) $display("FAIL crc_smp_done got %0d want %0d", n_sd, exp_sd); else n_pass++;
    n_chk++; if (fd_now !== 1'b1 || n_se != 0) $display("FAIL crc_frm got fd %b seq %0d want 1 0", fd_now, n_se); else n_pass++;
  endtask

  task automatic test_hdr_in_data();
    int b;
    clear_obs();
    send_frame(0, 1'b0, -1, 4, 40);
    cyc(1'b1, 1'b1, 1'b0, 16'($urandom));
    n_chk++; if (SEQ_ERR !== 1'b1) $display("FAIL hdrdata_seq got %b want 1", SEQ_ERR); else n_pass++;
    n_chk++; if (RCV_STATE !== 3'd1) $display("FAIL hdrdata_state got %0d want 1", RCV_STATE); else n_pass++;
    b = first_bad();
    n_chk++; if (b != -1) $display("FAIL hdrdata_partial idx %0d got %0d want 40 words", b, obs_q.size()); else n_pass++;
    clear_obs();
    send_frame(0, 1'b1, -1, 3, -1);
    idle(2);
    b = first_bad();
    n_chk++; if (b != -1 || n_sd != 1 || n_ce != 0 || n_se != 0 || fd_now !== 1'b1) $display("FAIL hdrdata_next got bad %0d done %0d crc %0d seq %0d fd %b want -1 1 0 0 1", b, n_sd, n_ce, n_se, fd_now); else n_pass++;
  endtask

  task automatic test_short_hdr();
    int b;
    clear_obs();
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 16'($urandom));
    cyc(1'b1, 1'b0, 1'b0, 16'($urandom));
    n_chk++; if (SEQ_ERR !== 1'b1 || RCV_STATE !== 3'd6) $display("FAIL shorthdr got seq %b state %0d want 1 6", SEQ_ERR, RCV_STATE); else n_pass++;
    repeat (10) cyc(1'b1, 1'b0, 1'b0, 16'($urandom));
    n_chk++; if (obs_q.size() != 0 || RCV_STATE !== 3'd6) $display("FAIL shorthdr_hunt got vld %0d state %0d want 0 6", obs_q.size(), RCV_STATE); else n_pass++;
    clear_obs();
    send_frame(0, 1'b0, -1, 4, -1);
    idle(1);
    b = first_bad();
    n_chk++; if (b != -1 || n_sd != 1 || n_se != 0 || fd_now !== 1'b1) $display("FAIL shorthdr_next got bad %0d done %0d seq %0d fd %b want -1 1 0 1", b, n_sd, n_se, fd_now); else n_pass++;
  endtask

  task automatic test_rst_mid();
    int b;
    clear_obs();
    send_frame(0, 1'b0, -1, 4, 50);
    RST = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 16'($urandom));
    n_chk++; if ({DOUT, DOUT_VLD, SMP, WRD} !== 31'h0 || RCV_STATE !== 3'd0) $display("FAIL rstmid_outs got dout %h vld %b smp %0d wrd %0d state %0d want all 0", DOUT, DOUT_VLD, SMP, WRD, RCV_STATE); else n_pass++;
    RST = 1'b0;
    clear_obs();
    idle(3);
    n_chk++; if (n_sd + n_ce + n_fd + n_se != 0) $display("FAIL rstmid_pulses got %0d want 0", n_sd + n_ce + n_fd + n_se); else n_pass++;
    send_frame(0, 1'b1, -1, 4, -1);
    idle(1);
    b = first_bad();
    n_chk++; if (b != -1 || n_sd != 1 || n_ce != 0 || n_se != 0 || fd_now !== 1'b1) $display("FAIL rstmid_next got bad %0d done %0d crc %0d seq %0d fd %b want -1 1 0 0 1", b, n_sd, n_ce, n_se, fd_now); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int b;
    clear_obs();
    send_frame(0, 1'b0, -1, 4, -1);
    send_frame(0, 1'b0, 0, 4, -1);
    idle(2);
    b = first_bad();
    n_chk++; if (b != -1 || obs_q.size() != 192) $display("FAIL b2b_data got bad %0d n %0d want -1 192", b, obs_q.size()); else n_pass++;
    n_chk++; if (n_fd != 2 || n_se != 0) $display("FAIL b2b_frm got fd %0d seq %0d want 2 0", n_fd, n_se); else n_pass++;
    n_chk++; if (n_sd != 2 || n_ce != 1 || ce_at != 1) $display("FAIL b2b_crc got done %0d crc %0d at %0d want 2 1 1", n_sd, n_ce, ce_at); else n_pass++;
  endtask

  initial begin
    RST = 1'b1; DV = 1'b0; HDR_FLG = 1'b0; LAST_FLG = 1'b0; DIN = 16'h0; SAMP_MAX = 7'd0;
    clear_obs();
    test_reset();
    test_clean();
    test_gaps();
    test_crc_err();
    test_hdr_in_data();
    test_short_hdr();
    test_rst_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/chnlnk_frame_rcvr_fsm.md
# chnlnk_frame_rcvr_fsm

Receive-side framer for the channel-link sample stream. It accepts the word stream produced by the channel-link frame transmitter: a 4-word header, then SAMP_MAX+1 samples of 96 data words and 3 tail words each, then a last-word marker. It checks word sequence, sample count and per-sample CRC, and forwards data words tagged with sample and word indices. It sits at the DAQ/test end of the link, after word alignment.

## Interface
- CRC_INIT, 16'hFFFF, CRC-16 seed loaded at start of each sample

- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- DIN  in  16  received word
- DV  in  1  DIN valid this cycle
- HDR_FLG  in  1  DIN is a header word (qualified by DV)
- LAST_FLG  in  1  end-of-frame marker; does not require DV
- SAMP_MAX  in  7  index of last sample in frame (quasi-static)
- DOUT  out  16  registered copy of accepted data word
- DOUT_VLD  out  1  DOUT holds a data word (seq 0..95)
- SMP  out  7  sample index of DOUT
- WRD  out  7  word index of DOUT
- SMP_DONE  out  1  one-cycle pulse, sample closed, CRC compared
- FRM_DONE  out  1  one-cycle pulse, frame closed cleanly
- CRC_ERR  out  1  one-cycle pulse, CRC mismatch at tail
- SEQ_ERR  out  1  one-cycle pulse, framing violation
- RCV_STATE  out  3  current state encoding, for debug

## Operation
- States: Idle(0), Hdr(1), W4Smp(2), Data(3), Tail(4), W4Last(5), Hunt(6).
- Idle: DV&HDR_FLG -> Hdr, wrd=1. DV without HDR_FLG is ignored.
- Hdr: each DV&HDR_FLG increments wrd. On the 4th header word (wrd==3 accepted) -> W4Smp, smp=0. DV without HDR_FLG before 4 header words -> SEQ_ERR, Hunt.
- W4Smp: the first DV word is data word 0. Load crc=CRC_INIT updated with DIN, wrd=1, assert DOUT_VLD -> Data.
- Data: each DV word goes to DOUT with WRD=wrd and feeds the CRC. After word 95 -> Tail, wrd=96.
- Tail: words 96 and 97 are status and are not checked. Word 98 is compared to the running CRC; mismatch gives a CRC_ERR pulse. SMP_DONE pulses either way. If smp==SAMP_MAX -> W4Last, else smp+1 -> W4Smp.
- W4Last: LAST_FLG -> FRM_DONE pulse -> Idle. Any DV -> SEQ_ERR, Hunt.
- Hunt: ignore everything until DV&HDR_FLG, then proceed as in Idle (-> Hdr, wrd=1).
- Global violations, each giving a SEQ_ERR pulse:
  - DV&HDR_FLG in any state other than Idle/Hdr/Hunt: restart header, -> Hdr, wrd=1.
  - LAST_FLG in any state other than W4Last/Idle/Hunt: -> Idle.
- DV low in any state holds state and counters; gaps are legal anywhere.
- CRC: CRC-16-CCITT (x^16+x^12+x^5+1), MSB-first, 16 bits per cycle, no final XOR.
- Counters are 7-bit and never wrap in legal operation. smp beyond SAMP_MAX cannot occur because the transition is decided by equality.
- Reset values: all pulses, DOUT_VLD 0; DOUT 0; SMP 0; WRD 0; RCV_STATE Idle; crc CRC_INIT.

## Timing
- All outputs registered. DOUT/DOUT_VLD/SMP/WRD appear the cycle after the DV word is sampled (latency 1).
- SMP_DONE and CRC_ERR appear 1 cycle after tail word 98 is sampled. FRM_DONE appears 1 cycle after LAST_FLG.
- Back-to-back frames: HDR_FLG in the cycle after LAST_FLG is accepted.
- Simultaneous events:
  - HDR_FLG and LAST_FLG together: HDR wins; FRM_DONE fires if in W4Last.
  - RST overrides everything in the same edge.
- Reset mid-frame returns to Idle; the partial frame produces no pulses.
- Minimum frame at SAMP_MAX=0 is 103 DV words plus LAST_FLG.

## Structure
- Shared package: state encodings, HDR_WORDS=4, LAST_DATA=95, LAST_TAIL=98, CRC polynomial constant. Shared with the transmitter so both ends agree.
- One sub-module, chnlnk_crc16: combinational 16-bit-parallel next-CRC function. The FSM holds the CRC register.
- FSM and datapath live in one module; no TMR is required on this side.

## Test plan
- SAMP_MAX=0, legal frame with correct CRC, no gaps -> 96 DOUT_VLD with WRD 0..95, SMP_DONE once, CRC_ERR never, FRM_DONE 1 cycle after LAST_FLG.
- SAMP_MAX=2, random DV gaps -> SMP reports 0,1,2; SMP_DONE pulses 3 times; FRM_DONE once; word order intact.
- Corrupt tail word 98 of sample 1 -> CRC_ERR with SMP_DONE for that sample only; frame still reaches FRM_DONE.
- HDR_FLG inserted at data word 40 -> SEQ_ERR pulse, RCV_STATE=Hdr; the following legal frame is received cleanly.
- Only 3 header words, then a data word -> SEQ_ERR, Hunt, no DOUT_VLD until the next header.
- RST asserted at data word 50 -> all outputs at reset values next cycle; the next legal frame passes.
